// File: rtl/jtag_dma_pkg.sv
// Shared definitions for the JTAG buffer <-> system bus burst DMA.
package jtag_dma_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CALC,
    S_PREFETCH,
    S_REQ,
    S_BEGIN,
    S_WDATA,
    S_WEND,
    S_RDATA,
    S_NEXT
  } state_t;

  localparam int BUS_WORD_BYTES = 4;
  localparam int BURST_SIZE_W   = 8;

endpackage

// File: rtl/jtag_dma_burst_calc.sv
// Beats for the next burst: min(remaining, MAX_BURST, words left before the next MAX_BURST-aligned boundary).
// Purely combinational, no handshake.
module jtag_dma_burst_calc
  import jtag_dma_pkg::*;
#(
  parameter int BUF_ADDR_W = 9,
  parameter int MAX_BURST  = 16
) (
  input  logic [BUF_ADDR_W:0]   remaining,
  input  logic [31:0]           addr,
  output logic [BURST_SIZE_W:0] beats
);

  localparam int LOG_MAX_BURST = $clog2(MAX_BURST);

  logic [31:0] word_off;
  logic [31:0] room;
  logic [31:0] rem_ext;
  logic [31:0] pick;

  always_comb begin
    word_off = (addr >> 2) & 32'((1 << LOG_MAX_BURST) - 1);
    room     = 32'(MAX_BURST) - word_off;
    rem_ext  = 32'(remaining);
    pick     = (rem_ext < room) ? rem_ext : room;
    beats    = (BURST_SIZE_W + 1)'(pick);
  end

endmodule

// File: rtl/jtag_burst_dma.sv
// Bus-master DMA between the JTAG word buffer and the system bus, split into aligned bursts.
// Full-rate beats with no bubbles; write beats stall while busyIN is high, errorIN aborts next cycle.
module jtag_burst_dma
  import jtag_dma_pkg::*;
#(
  parameter int BUF_ADDR_W = 9,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  dir_read,
  input  logic [31:0]           bus_addr,
  input  logic [BUF_ADDR_W-1:0] buf_addr,
  input  logic [BUF_ADDR_W:0]   word_count,
  input  logic [3:0]            byte_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [BUF_ADDR_W-1:0] bufferAddress,
  output logic [31:0]           dataIn,
  output logic                  writeEnable,
  input  logic [31:0]           dataOut,
  input  logic [31:0]           address_dataIN,
  input  logic                  end_transactionIN,
  input  logic                  data_validIN,
  input  logic                  busyIN,
  input  logic                  errorIN,
  output logic [31:0]           address_dataOUT,
  output logic [3:0]            byte_enableOUT,
  output logic [7:0]            burst_sizeOUT,
  output logic                  read_n_writeOUT,
  output logic                  begin_transactionOUT,
  output logic                  end_transactionOUT,
  output logic                  data_validOUT,
  output logic                  busyOUT,
  output logic                  request,
  input  logic                  granted
);

  localparam int BW = BURST_SIZE_W + 1;
  localparam int RW = BUF_ADDR_W + 1;

  state_t                state_q, state_d;
  logic                  dir_q;
  logic [31:0]           addr_q;
  logic [BUF_ADDR_W-1:0] ptr_q;
  logic [RW-1:0]         rem_q;
  logic [RW-1:0]         rem_next;
  logic [3:0]            be_q;
  logic [BW-1:0]         beats_q;
  logic [BW-1:0]         cnt_q;
  logic [BW-1:0]         calc_beats;
  logic                  error_q;
  logic                  done_q;
  logic                  abort_end_q;
  logic                  abort;
  logic                  beat_acc;
  logic                  last_beat;
  logic                  rd_take;

  jtag_dma_burst_calc #(
    .BUF_ADDR_W(BUF_ADDR_W),
    .MAX_BURST (MAX_BURST)
  ) u_calc (
    .remaining(rem_q),
    .addr     (addr_q),
    .beats    (calc_beats)
  );

  assign abort     = errorIN && (state_q inside {S_REQ, S_BEGIN, S_WDATA, S_WEND, S_RDATA});
  assign beat_acc  = (state_q == S_WDATA) && !busyIN && !errorIN;
  assign last_beat = (cnt_q == beats_q - BW'(1));
  // Slave beats past the programmed count are dropped rather than overrunning the buffer region.
  assign rd_take   = (state_q == S_RDATA) && data_validIN && !errorIN && (cnt_q < beats_q);
  assign rem_next  = rem_q - RW'(beats_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d              = state_q;
    busy                 = (state_q != S_IDLE);
    done                 = done_q;
    error                = error_q;
    bufferAddress        = '0;
    dataIn               = '0;
    writeEnable          = 1'b0;
    address_dataOUT      = '0;
    byte_enableOUT       = '0;
    burst_sizeOUT        = '0;
    read_n_writeOUT      = 1'b0;
    begin_transactionOUT = 1'b0;
    end_transactionOUT   = abort_end_q;
    data_validOUT        = 1'b0;
    busyOUT              = 1'b0;
    request              = 1'b0;

    // Keep re-reading the current word so dataOut is valid when WDATA starts.
    if (state_q != S_IDLE) bufferAddress = beat_acc ? ptr_q + BUF_ADDR_W'(1) : ptr_q;

    case (state_q)
      S_IDLE:     if (start && word_count != '0) state_d = S_CALC;
      S_CALC:     state_d = dir_q ? S_REQ : S_PREFETCH;
      S_PREFETCH: state_d = S_REQ;
      S_REQ: begin
        request = 1'b1;
        if (granted) state_d = S_BEGIN;
      end
      S_BEGIN: begin
        begin_transactionOUT = 1'b1;
        address_dataOUT      = addr_q;
        byte_enableOUT       = be_q;
        burst_sizeOUT        = BURST_SIZE_W'(beats_q - BW'(1));
        read_n_writeOUT      = dir_q;
        state_d              = dir_q ? S_RDATA : S_WDATA;
      end
      S_WDATA: begin
        data_validOUT   = 1'b1;
        address_dataOUT = dataOut;
        if (beat_acc && last_beat) state_d = S_WEND;
      end
      S_WEND: begin
        end_transactionOUT = 1'b1;
        state_d            = S_NEXT;
      end
      S_RDATA: begin
        writeEnable = rd_take;
        dataIn      = address_dataIN;
        if (end_transactionIN) state_d = S_NEXT;
      end
      S_NEXT:  state_d = (rem_next == '0) ? S_IDLE : S_CALC;
      default: state_d = S_IDLE;
    endcase

    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dir_q       <= 1'b0;
      addr_q      <= '0;
      ptr_q       <= '0;
      rem_q       <= '0;
      be_q        <= '0;
      beats_q     <= '0;
      cnt_q       <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      abort_end_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      abort_end_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dir_q   <= dir_read;
            addr_q  <= bus_addr & 32'hFFFF_FFFC;
            ptr_q   <= buf_addr;
            rem_q   <= word_count;
            be_q    <= byte_enable;
            error_q <= 1'b0;
            if (word_count == '0) done_q <= 1'b1;
          end
        end
        S_CALC: begin
          beats_q <= calc_beats;
          cnt_q   <= '0;
        end
        S_WDATA, S_RDATA: begin
          if (beat_acc || rd_take) begin
            ptr_q <= ptr_q + BUF_ADDR_W'(1);
            cnt_q <= cnt_q + BW'(1);
          end
        end
        S_NEXT: begin
          addr_q <= addr_q + 32'(beats_q) * 32'(BUS_WORD_BYTES);
          rem_q  <= rem_next;
          if (rem_next == '0) done_q <= 1'b1;
        end
        default: ;
      endcase
      if (abort) begin
        error_q     <= 1'b1;
        done_q      <= 1'b1;
        abort_end_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtag_burst_dma.sv
// Scoreboard bench for jtag_burst_dma: directed commands push expected bus/buffer events, a monitor pops and compares.
module tb_jtag_burst_dma;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        dir_read = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [8:0]  buf_addr = '0;
  logic [9:0]  word_count = '0;
  logic [3:0]  byte_enable = '0;
  logic        busy, done, error;
  logic [8:0]  bufferAddress;
  logic [31:0] dataIn;
  logic        writeEnable;
  logic [31:0] dataOut = '0;
  logic [31:0] address_dataIN = '0;
  logic        end_transactionIN = 1'b0;
  logic        data_validIN = 1'b0;
  logic        busyIN = 1'b0;
  logic        errorIN = 1'b0;
  logic [31:0] address_dataOUT;
  logic [3:0]  byte_enableOUT;
  logic [7:0]  burst_sizeOUT;
  logic        read_n_writeOUT, begin_transactionOUT, end_transactionOUT;
  logic        data_validOUT, busyOUT, request;
  logic        granted = 1'b1;

  always #5 clock = ~clock;

  jtag_burst_dma #(.BUF_ADDR_W(9), .MAX_BURST(16)) dut (
    .clock(clock), .reset(reset), .start(start), .dir_read(dir_read),
    .bus_addr(bus_addr), .buf_addr(buf_addr), .word_count(word_count),
    .byte_enable(byte_enable), .busy(busy), .done(done), .error(error),
    .bufferAddress(bufferAddress), .dataIn(dataIn), .writeEnable(writeEnable),
    .dataOut(dataOut), .address_dataIN(address_dataIN),
    .end_transactionIN(end_transactionIN), .data_validIN(data_validIN),
    .busyIN(busyIN), .errorIN(errorIN), .address_dataOUT(address_dataOUT),
    .byte_enableOUT(byte_enableOUT), .burst_sizeOUT(burst_sizeOUT),
    .read_n_writeOUT(read_n_writeOUT), .begin_transactionOUT(begin_transactionOUT),
    .end_transactionOUT(end_transactionOUT), .data_validOUT(data_validOUT),
    .busyOUT(busyOUT), .request(request), .granted(granted)
  );

  // Dual-port buffer model with one-cycle synchronous read.
  logic        tb_init = 1'b1;
  logic [31:0] mem [0:511];
  always @(posedge clock) begin
    if (tb_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hD000_0000 + i;
      dataOut <= '0;
    end else begin
      if (writeEnable) mem[bufferAddress] <= dataIn;
      dataOut <= mem[bufferAddress];
    end
  end

  localparam int EV_BEGIN = 0, EV_WBEAT = 1, EV_BUFWR = 2, EV_END = 3, EV_DONE = 4;
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;
  ev_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   begin_cyc = 0;
  int   end_cyc = 0;
  int   req_rises = 0;
  logic req_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic push(input int k, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    e.kind = k; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] mkb(input logic rnw, input logic [3:0] be, input int len);
    return {19'd0, rnw, be, 8'(len - 1)};
  endfunction

  task automatic sb_take(input int k, input logic [31:0] a, input logic [31:0] b, input string name);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected event actual=%h/%h expected=none", name, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a !== a || e.b !== b) begin
        errors++;
        $display("FAIL %s actual kind=%0d a=%h b=%h expected kind=%0d a=%h b=%h",
                 name, k, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      if (request && !req_prev) req_rises++;
      if (begin_transactionOUT) begin
        begin_cyc = cyc;
        sb_take(EV_BEGIN, address_dataOUT, {19'd0, read_n_writeOUT, byte_enableOUT, burst_sizeOUT}, "begin");
      end
      if (data_validOUT && busyIN && exp_q.size() > 0 && exp_q[0].kind == EV_WBEAT)
        chk("stall_word", address_dataOUT, exp_q[0].a);
      if (data_validOUT && !busyIN) sb_take(EV_WBEAT, address_dataOUT, 32'd0, "wbeat");
      if (writeEnable) sb_take(EV_BUFWR, {23'd0, bufferAddress}, dataIn, "bufwr");
      if (end_transactionOUT) begin
        end_cyc = cyc;
        sb_take(EV_END, 32'd0, 32'd0, "end");
      end
      if (done) sb_take(EV_DONE, {31'd0, error}, 32'd0, "done");
      if (busyOUT) chk("busyOUT", {31'd0, busyOUT}, 32'd0);
    end
    req_prev = request;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic rd, input logic [31:0] ba, input logic [8:0] bf,
                          input logic [9:0] wc, input logic [3:0] be);
    dir_read = rd; bus_addr = ba; buf_addr = bf; word_count = wc; byte_enable = be;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin tick(); n++; end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting for done actual=0 expected=1", name);
    end
  endtask

  task automatic wait_begin(input string name);
    int n = 0;
    while (!begin_transactionOUT && n < 50) begin tick(); n++; end
    if (!begin_transactionOUT) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting for begin actual=0 expected=1", name);
    end
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ctl"}, {1'b0, busy, done, error, writeEnable, read_n_writeOUT, begin_transactionOUT,
                         end_transactionOUT, data_validOUT, busyOUT, request, byte_enableOUT,
                         burst_sizeOUT, bufferAddress}, 32'd0);
    chk({name, "_data"}, address_dataOUT | dataIn, 32'd0);
  endtask

  initial begin
    int r0, seen, stall, n;
    #1 reset = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) tick();
    tb_init = 1'b0;
    reset   = 1'b1;
    tick();

    // Single 5-beat write burst, back-to-back beats.
    push(EV_BEGIN, 32'h4000_0000, mkb(1'b0, 4'hF, 5));
    for (int i = 0; i < 5; i++) push(EV_WBEAT, 32'hD000_0000 + i, 32'd0);
    push(EV_END, 32'd0, 32'd0);
    push(EV_DONE, 32'd0, 32'd0);
    do_start(1'b0, 32'h4000_0000, 9'h000, 10'd5, 4'hF);
    wait_done("t1", 100);
    tick();
    chk("t1_back_to_back", 32'(end_cyc - begin_cyc), 32'd6);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // 20 words from 0x..38: 2 + 16 + 2 beats across aligned boundaries.
    r0 = req_rises;
    begin
      logic [31:0] ba [3];
      int          len [3];
      int          w;
      ba[0] = 32'h4000_0038; ba[1] = 32'h4000_0040; ba[2] = 32'h4000_0080;
      len[0] = 2; len[1] = 16; len[2] = 2;
      w = 16;
      for (int b = 0; b < 3; b++) begin
        push(EV_BEGIN, ba[b], mkb(1'b0, 4'h3, len[b]));
        for (int i = 0; i < len[b]; i++) begin
          push(EV_WBEAT, 32'hD000_0000 + w, 32'd0);
          w++;
        end
        push(EV_END, 32'd0, 32'd0);
      end
    end
    push(EV_DONE, 32'd0, 32'd0);
    do_start(1'b0, 32'h4000_003B, 9'h010, 10'd20, 4'h3);
    wait_done("t2", 300);
    tick();
    chk("t2_request_bursts", 32'(req_rises - r0), 32'd3);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // busyIN held 3 cycles on beat 2; word repeated, beat count unchanged.
    push(EV_BEGIN, 32'h4000_1000, mkb(1'b0, 4'hF, 5));
    for (int i = 0; i < 5; i++) push(EV_WBEAT, 32'hD000_0040 + i, 32'd0);
    push(EV_END, 32'd0, 32'd0);
    push(EV_DONE, 32'd0, 32'd0);
    do_start(1'b0, 32'h4000_1000, 9'h040, 10'd5, 4'hF);
    seen = 0; stall = 3; n = 0;
    while (!done && n < 200) begin
      if (data_validOUT && seen == 2 && stall > 0) begin busyIN = 1'b1; stall--; end
      else busyIN = 1'b0;
      if (data_validOUT && !busyIN) seen++;
      tick();
      n++;
    end
    busyIN = 1'b0;
    wait_done("t3", 1);
    tick();
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4-word read wrapping the buffer pointer from 0x1FE.
    push(EV_BEGIN, 32'h2000_0000, mkb(1'b1, 4'hF, 4));
    push(EV_BUFWR, 32'h1FE, 32'h0000_00A0);
    push(EV_BUFWR, 32'h1FF, 32'h0000_00A1);
    push(EV_BUFWR, 32'h000, 32'h0000_00A2);
    push(EV_BUFWR, 32'h001, 32'h0000_00A3);
    push(EV_DONE, 32'd0, 32'd0);
    do_start(1'b1, 32'h2000_0000, 9'h1FE, 10'd4, 4'hF);
    wait_begin("t4");
    tick();
    for (int i = 0; i < 4; i++) begin
      data_validIN = 1'b1;
      address_dataIN = 32'h0000_00A0 + i;
      end_transactionIN = (i == 3);
      tick();
    end
    data_validIN = 1'b0; end_transactionIN = 1'b0;
    wait_done("t4", 50);
    tick();
    chk("t4_mem_1fe", mem[9'h1FE], 32'h0000_00A0);
    chk("t4_mem_001", mem[9'h001], 32'h0000_00A3);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // errorIN on beat 3 of an 8-beat read.
    push(EV_BEGIN, 32'h3000_0000, mkb(1'b1, 4'hF, 8));
    for (int i = 0; i < 3; i++) push(EV_BUFWR, 32'h100 + i, 32'h0000_00B0 + i);
    push(EV_END, 32'd0, 32'd0);
    push(EV_DONE, 32'd1, 32'd0);
    do_start(1'b1, 32'h3000_0000, 9'h100, 10'd8, 4'hF);
    wait_begin("t5");
    tick();
    for (int i = 0; i < 4; i++) begin
      data_validIN = 1'b1;
      address_dataIN = 32'h0000_00B0 + i;
      errorIN = (i == 3);
      tick();
    end
    data_validIN = 1'b0; errorIN = 1'b0;
    chk("t5_done_next_cycle", {31'd0, done}, 32'd1);
    chk("t5_error_set", {31'd0, error}, 32'd1);
    chk("t5_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("t5_error_sticky", {31'd0, error}, 32'd1);
    chk("t5_mem_102", mem[9'h102], 32'h0000_00B2);
    chk("t5_mem_103_kept", mem[9'h103], 32'hD000_0103);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
    push(EV_DONE, 32'd0, 32'd0);
    do_start(1'b0, 32'h0, 9'h0, 10'd0, 4'hF);
    chk("t5_wc0_done", {31'd0, done}, 32'd1);
    chk("t5_error_cleared", {31'd0, error}, 32'd0);
    tick();
    errorIN = 1'b1;
    tick();
    errorIN = 1'b0;
    chk("idle_error_ignored", {31'd0, error}, 32'd0);

    // Reset while in WDATA, then a zero-length command.
    push(EV_BEGIN, 32'h5000_0000, mkb(1'b0, 4'hF, 8));
    busyIN = 1'b1;
    do_start(1'b0, 32'h5000_0000, 9'h020, 10'd8, 4'hF);
    n = 0;
    while (!data_validOUT && n < 50) begin tick(); n++; end
    chk("t6_in_wdata", {31'd0, data_validOUT}, 32'd1);
    tick();
    reset = 1'b0;
    #1 check_all_zero("t6_reset");
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    busyIN = 1'b0;
    tick();
    r0 = req_rises;
    push(EV_DONE, 32'd0, 32'd0);
    do_start(1'b0, 32'h0, 9'h0, 10'd0, 4'hF);
    chk("t6_wc0_done", {31'd0, done}, 32'd1);
    tick();
    tick();
    chk("t6_no_request", 32'(req_rises - r0), 32'd0);
    chk("t6_final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
